// File: rtl/mac_operand_sequencer.sv
// Sequences one dot product through an external MAC: it clears the accumulator, then
// streams VEC_LEN joined A/B operand pairs into it, then captures the final Cout.
module mac_operand_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    a_valid,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    b_ready,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic [3*DATA_WIDTH-1:0] result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy,
  output logic [2:0]              state_dbg
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    CAPT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          fire;

  // Valid/ready: a pair transfers only on a cycle where both valids are high in RUN;
  // both readies then rise together, so neither stream is ever consumed on its own.
  assign fire      = (state == RUN) && a_valid && b_valid;
  assign a_ready   = fire;
  assign b_ready   = fire;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      mac_en       <= 1'b0;
      mac_clr      <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            mac_clr <= 1'b1;
          end
        end
        CLEAR: begin
          count <= '0;
          state <= RUN;
        end
        RUN: begin
          if (fire) begin
            mac_a  <= a_data;
            mac_b  <= b_data;
            mac_en <= 1'b1;
            count  <= count + 1'b1;
            if (count == LAST) state <= DRAIN;
          end
        end
        // The MAC folds in the last pair at the end of DRAIN, so Cout is final in CAPT.
        DRAIN: state <= CAPT;
        CAPT: begin
          result       <= mac_cout;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (start) begin
              state   <= CLEAR;
              mac_clr <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: behavioural MAC, randomized operand streams and a
// dot-product reference model feeding an expected-result queue.
module tb_mac_operand_sequencer;

  localparam int DW = 8;
  localparam int RW = 3 * DW;
  localparam int VL = 8;
  localparam int LONG_VL = 300;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, a_valid, b_valid, result_ready;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, mac_en, mac_clr, result_valid, busy;
  logic [DW-1:0] mac_a, mac_b;
  logic [RW-1:0] mac_cout, result;
  logic [2:0]    state_dbg;

  logic          l_start;
  logic          l_a_ready, l_b_ready, l_mac_en, l_mac_clr, l_result_valid, l_busy;
  logic [DW-1:0] l_mac_a, l_mac_b;
  logic [RW-1:0] l_mac_cout, l_result;
  logic [2:0]    l_state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int results_seen = 0;
  logic [RW-1:0] exp_q[$];
  int av[$];
  int bv[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs and behavioural MACs ----------------
  mac_operand_sequencer #(.DATA_WIDTH(DW), .VEC_LEN(VL)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_cout(mac_cout), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy), .state_dbg(state_dbg)
  );

  mac_operand_sequencer #(.DATA_WIDTH(DW), .VEC_LEN(LONG_VL)) u_long (
    .clk(clk), .rst_n(rst_n), .start(l_start),
    .a_valid(1'b1), .a_data(8'hFF), .a_ready(l_a_ready),
    .b_valid(1'b1), .b_data(8'hFF), .b_ready(l_b_ready),
    .mac_en(l_mac_en), .mac_clr(l_mac_clr), .mac_a(l_mac_a), .mac_b(l_mac_b),
    .mac_cout(l_mac_cout), .result(l_result), .result_valid(l_result_valid),
    .result_ready(1'b1), .busy(l_busy), .state_dbg(l_state_dbg)
  );

  logic [RW-1:0] acc = '0;
  logic [RW-1:0] l_acc = '0;
  assign mac_cout   = acc;
  assign l_mac_cout = l_acc;

  always @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= acc + RW'(mac_a) * RW'(mac_b);
    if (l_mac_clr) l_acc <= '0;
    else if (l_mac_en) l_acc <= l_acc + RW'(l_mac_a) * RW'(l_mac_b);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] dot_ref();
    longint s = 0;
    for (int i = 0; i < av.size(); i++) s += longint'(av[i]) * longint'(bv[i]);
    return RW'(s % (longint'(1) << RW));
  endfunction

  // ---------------- protocol / result scoreboard ----------------
  logic          prev_fire, prev_clr, prev_rv;
  logic [RW-1:0] prev_res;
  logic [2*DW-1:0] held_ab;
  int last_fire_cyc, en_cnt;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_fire = 1'b0; prev_clr = 1'b0; prev_rv = 1'b0; prev_res = '0;
      held_ab = '0; en_cnt = 0; last_fire_cyc = 0;
    end else begin
      check("ready_equal", a_ready, b_ready);
      if (a_ready) check("ready_join", a_valid & b_valid, 1);
      check("en_follows_fire", mac_en, prev_fire);
      check("mac_operands", {mac_a, mac_b}, held_ab);
      check("clr_en_exclusive", mac_clr & mac_en, 0);
      check("clr_single_cycle", mac_clr & prev_clr, 0);
      if (mac_en) en_cnt++;
      if (result_valid && !prev_rv) begin
        results_seen++;
        check("result_latency", cyc - last_fire_cyc, 3);
        check("en_cycles", en_cnt, VL);
        en_cnt = 0;
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("result", result, exp_q.pop_front());
      end
      if (result_valid && prev_rv) check("result_hold", result, prev_res);
      if (a_ready) begin
        held_ab = {a_data, b_data};
        last_fire_cyc = cyc;
      end
      prev_fire = a_ready;
      prev_clr  = mac_clr;
      prev_rv   = result_valid;
      prev_res  = result;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_vec(input int kind);
    av.delete(); bv.delete();
    for (int i = 0; i < VL; i++) begin
      case (kind)
        0: begin av.push_back(i + 1); bv.push_back(2); end
        1: begin av.push_back(255);   bv.push_back(255); end
        2: begin av.push_back(3);     bv.push_back(3); end
        default: begin av.push_back($urandom_range(0, 255)); bv.push_back($urandom_range(0, 255)); end
      endcase
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("clr_after_start", mac_clr, 1);
    check("busy_after_start", busy, 1);
  endtask

  // mode 0: back-to-back pairs; 1: random one-sided gaps; 2: A waits alone before pair 0
  task automatic send_pairs(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == 1) begin
        int g = $urandom_range(0, 5);
        for (int k = 0; k < g; k++) begin
          int r = $urandom_range(0, 2);
          a_valid = (r == 1); b_valid = (r == 2);
          a_data = DW'($urandom); b_data = DW'($urandom);
          @(negedge clk);
          check("gap_ready", a_ready | b_ready, 0);
          @(posedge clk); #1;
        end
      end
      if (mode == 2 && i == 0) begin
        a_valid = 1'b1; b_valid = 1'b0; a_data = DW'(av[0]);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("a_alone_ready", a_ready, 0);
          check("a_alone_en", mac_en, 0);
          @(posedge clk); #1;
        end
      end
      a_valid = 1'b1; b_valid = 1'b1;
      a_data = DW'(av[i]); b_data = DW'(bv[i]);
      begin
        int t = 0;
        @(negedge clk);
        while (!a_ready && t < 50) begin
          @(negedge clk);
          t++;
        end
        check("fire_timeout", a_ready, 1);
      end
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
    end
  endtask

  task automatic wait_result();
    int t = 0;
    @(negedge clk);
    while (!result_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("result_timeout", result_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_dot(input int kind, input int mode);
    set_vec(kind);
    exp_q.push_back(dot_ref());
    do_start();
    send_pairs(VL, mode);
    wait_result();
    @(negedge clk);
    check("busy_after_done", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {a_ready, b_ready}, 0);
    check({tag, "_mac_ctl"}, {mac_en, mac_clr}, 0);
    check({tag, "_mac_ops"}, {mac_a, mac_b}, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_rvalid_busy"}, {result_valid, busy}, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0; result_ready = 1'b1; l_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_dot(0, 0);
    run_dot(0, 1);
    run_dot(0, 2);
    run_dot(1, 0);
    for (int n = 0; n < 6; n++) run_dot(3, $urandom_range(0, 1));

    // Result held while downstream stalls, start ignored, then back-to-back restart.
    result_ready = 1'b0;
    set_vec(3);
    exp_q.push_back(dot_ref());
    do_start();
    send_pairs(VL, 1);
    begin
      int t = 0;
      @(negedge clk);
      while (!result_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("stall_result_timeout", result_valid, 1);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      if (k >= 5) start = 1'b1;
      @(negedge clk);
      check("stall_valid", result_valid, 1);
      check("stall_no_clr", mac_clr, 0);
      @(posedge clk); #1;
    end
    set_vec(0);
    exp_q.push_back(dot_ref());
    result_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_clr", mac_clr, 1);
    check("b2b_valid_drop", result_valid, 0);
    send_pairs(VL, 0);
    wait_result();

    // Abort after four pairs; the next dot product must not see stale accumulation.
    set_vec(2);
    do_start();
    send_pairs(4, 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_dot(2, 0);

    // Long vector wraps modulo 2^24.
    l_start = 1'b1;
    @(posedge clk); #1;
    l_start = 1'b0;
    begin
      int t = 0;
      longint lexp = (longint'(LONG_VL) * 255 * 255) % (longint'(1) << RW);
      while (!l_result_valid && t < 400) begin
        @(posedge clk); #1;
        t++;
      end
      check("long_result_timeout", l_result_valid, 1);
      check("long_result_wrap", l_result, 32'(lexp));
    end

    repeat (3) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("results_seen", results_seen, 13);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
